// File: rtl/id_pkg.sv
// Shared definitions for the instruction-decode stage: opcode values,
// ALU command encodings, instruction field positions and the decoded
// control bundle, plus the opcode decoder used by the stage.
package id_pkg;

   localparam int DATA_W    = 32;
   localparam int REG_COUNT = 32;
   localparam int REG_AW    = 5;

   // Instruction field positions
   localparam int OPC_HI  = 31;
   localparam int OPC_LO  = 26;
   localparam int DEST_HI = 25;
   localparam int DEST_LO = 21;
   localparam int SRC1_HI = 20;
   localparam int SRC1_LO = 16;
   localparam int SRC2_HI = 15;
   localparam int SRC2_LO = 11;
   localparam int IMM_HI  = 15;
   localparam int IMM_LO  = 0;

   // Opcodes
   localparam logic [5:0] OP_NOP  = 6'd0;
   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd3;
   localparam logic [5:0] OP_AND  = 6'd5;
   localparam logic [5:0] OP_OR   = 6'd6;
   localparam logic [5:0] OP_XOR  = 6'd8;
   localparam logic [5:0] OP_SLA  = 6'd9;
   localparam logic [5:0] OP_SRL  = 6'd10;
   localparam logic [5:0] OP_ADDI = 6'd32;
   localparam logic [5:0] OP_LD   = 6'd36;
   localparam logic [5:0] OP_ST   = 6'd37;
   localparam logic [5:0] OP_BEZ  = 6'd40;
   localparam logic [5:0] OP_BNE  = 6'd41;
   localparam logic [5:0] OP_JMP  = 6'd42;

   // ALU commands carried to EX; loads/stores/ADDI use ADD for address/sum
   typedef enum logic [3:0] {
      CMD_NOP = 4'd0,
      CMD_ADD = 4'd1,
      CMD_SUB = 4'd2,
      CMD_AND = 4'd3,
      CMD_OR  = 4'd4,
      CMD_XOR = 4'd5,
      CMD_SLA = 4'd6,
      CMD_SRL = 4'd7
   } alu_cmd_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_EZ   = 2'd1,
      BR_NE   = 2'd2,
      BR_JMP  = 2'd3
   } br_kind_e;

   // valid: the instruction enters ID/EX as real work (not NOP/branch)
   typedef struct packed {
      logic     valid;
      alu_cmd_e cmd;
      logic     mem_r;
      logic     mem_w;
      logic     wb;
      logic     use_imm;
      logic     rd_src1;
      logic     rd_src2;
      logic     rd_dest;
      br_kind_e br;
   } ctrl_t;

   function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
      return {{(DATA_W-16){v[15]}}, v};
   endfunction

   // Unknown opcodes fall through to the all-zero (NOP) bundle
   function automatic ctrl_t decode(input logic [5:0] opc);
      ctrl_t c;
      c = '0;
      case (opc)
         OP_ADD:  begin c.valid = 1'b1; c.wb = 1'b1; c.rd_src1 = 1'b1; c.rd_src2 = 1'b1; c.cmd = CMD_ADD; end
         OP_SUB:  begin c.valid = 1'b1; c.wb = 1'b1; c.rd_src1 = 1'b1; c.rd_src2 = 1'b1; c.cmd = CMD_SUB; end
         OP_AND:  begin c.valid = 1'b1; c.wb = 1'b1; c.rd_src1 = 1'b1; c.rd_src2 = 1'b1; c.cmd = CMD_AND; end
         OP_OR:   begin c.valid = 1'b1; c.wb = 1'b1; c.rd_src1 = 1'b1; c.rd_src2 = 1'b1; c.cmd = CMD_OR;  end
         OP_XOR:  begin c.valid = 1'b1; c.wb = 1'b1; c.rd_src1 = 1'b1; c.rd_src2 = 1'b1; c.cmd = CMD_XOR; end
         OP_SLA:  begin c.valid = 1'b1; c.wb = 1'b1; c.rd_src1 = 1'b1; c.rd_src2 = 1'b1; c.cmd = CMD_SLA; end
         OP_SRL:  begin c.valid = 1'b1; c.wb = 1'b1; c.rd_src1 = 1'b1; c.rd_src2 = 1'b1; c.cmd = CMD_SRL; end
         OP_ADDI: begin c.valid = 1'b1; c.wb = 1'b1; c.rd_src1 = 1'b1; c.use_imm = 1'b1; c.cmd = CMD_ADD; end
         OP_LD:   begin c.valid = 1'b1; c.wb = 1'b1; c.mem_r = 1'b1; c.rd_src1 = 1'b1; c.use_imm = 1'b1; c.cmd = CMD_ADD; end
         OP_ST:   begin c.valid = 1'b1; c.mem_w = 1'b1; c.rd_src1 = 1'b1; c.rd_dest = 1'b1; c.use_imm = 1'b1; c.cmd = CMD_ADD; end
         OP_BEZ:  begin c.br = BR_EZ; c.rd_src1 = 1'b1; end
         OP_BNE:  begin c.br = BR_NE; c.rd_src1 = 1'b1; c.rd_dest = 1'b1; end
         OP_JMP:  begin c.br = BR_JMP; end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// Signal bundle between fetch / write-back (master side) and the decode
// stage (slave side). Fetch presents pc_in/instr_in every cycle and holds
// them while hazard=1; br_taken doubles as the fetch flush. Write-back is
// a fire-and-forget strobe: wb_en qualifies wb_dest/wb_value for one cycle.
interface id_stage_if;
   import id_pkg::*;

   logic [DATA_W-1:0] pc_in;
   logic [DATA_W-1:0] instr_in;
   logic              wb_en;
   logic [REG_AW-1:0] wb_dest;
   logic [DATA_W-1:0] wb_value;
   logic              br_taken;
   logic [DATA_W-1:0] br_addr;
   logic              hazard;
   logic [DATA_W-1:0] ex_pc;
   logic [DATA_W-1:0] ex_val1;
   logic [DATA_W-1:0] ex_val2;
   logic [DATA_W-1:0] ex_st_val;
   logic [REG_AW-1:0] ex_dest;
   logic [REG_AW-1:0] ex_src1;
   logic [REG_AW-1:0] ex_src2;
   logic [3:0]        ex_cmd;
   logic              ex_mem_r;
   logic              ex_mem_w;
   logic              ex_wb;

   modport master (
      output pc_in, instr_in, wb_en, wb_dest, wb_value,
      input  br_taken, br_addr, hazard, ex_pc, ex_val1, ex_val2, ex_st_val,
             ex_dest, ex_src1, ex_src2, ex_cmd, ex_mem_r, ex_mem_w, ex_wb
   );

   modport slave (
      input  pc_in, instr_in, wb_en, wb_dest, wb_value,
      output br_taken, br_addr, hazard, ex_pc, ex_val1, ex_val2, ex_st_val,
             ex_dest, ex_src1, ex_src2, ex_cmd, ex_mem_r, ex_mem_w, ex_wb
   );
endinterface

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: three combinational read ports (src1, src2, dest),
// one synchronous write port. r0 always reads zero; a read of the index
// being written this cycle returns the incoming write data.
module id_stage_reg_file
   import id_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [REG_AW-1:0] i_raddr1,
   input  logic [REG_AW-1:0] i_raddr2,
   input  logic [REG_AW-1:0] i_raddr3,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2,
   output logic [DATA_W-1:0] o_rdata3
);

   logic [DATA_W-1:0] r_mem [0:REG_COUNT-1];
   logic              w_wr;

   assign w_wr = i_we && (i_waddr != '0);

   // Storage: cleared by reset, r0 never written
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   function automatic logic [DATA_W-1:0] rd_port(input logic [REG_AW-1:0] a);
      if (a == '0)
         return '0;
      else if (w_wr && (a == i_waddr))
         return i_wdata;
      else
         return r_mem[a];
   endfunction

   assign o_rdata1 = rd_port(i_raddr1);
   assign o_rdata2 = rd_port(i_raddr2);
   assign o_rdata3 = rd_port(i_raddr3);

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: splits the fetched instruction, reads the
// register file, resolves branches back to fetch, detects load-use
// hazards and registers the decoded instruction into ID/EX.
module id_stage
   import id_pkg::*;
(
   input logic       clk,
   input logic       rst,
   id_stage_if.slave bus
);

   logic [5:0]        w_opc;
   logic [REG_AW-1:0] w_dest;
   logic [REG_AW-1:0] w_src1;
   logic [REG_AW-1:0] w_src2;
   logic [15:0]       w_imm;
   logic [DATA_W-1:0] w_imm_sext;
   ctrl_t             w_ctrl;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic [DATA_W-1:0] w_rd3;
   logic              w_hazard;
   logic              w_cond;
   logic              w_taken;
   logic              w_load;
   logic [DATA_W-1:0] w_br_addr;

   logic [DATA_W-1:0] r_ex_pc;
   logic [DATA_W-1:0] r_ex_val1;
   logic [DATA_W-1:0] r_ex_val2;
   logic [DATA_W-1:0] r_ex_st_val;
   logic [REG_AW-1:0] r_ex_dest;
   logic [REG_AW-1:0] r_ex_src1;
   logic [REG_AW-1:0] r_ex_src2;
   alu_cmd_e          r_ex_cmd;
   logic              r_ex_mem_r;
   logic              r_ex_mem_w;
   logic              r_ex_wb;

   assign w_opc      = bus.instr_in[OPC_HI:OPC_LO];
   assign w_dest     = bus.instr_in[DEST_HI:DEST_LO];
   assign w_src1     = bus.instr_in[SRC1_HI:SRC1_LO];
   assign w_src2     = bus.instr_in[SRC2_HI:SRC2_LO];
   assign w_imm      = bus.instr_in[IMM_HI:IMM_LO];
   assign w_imm_sext = sext16(w_imm);
   assign w_ctrl     = decode(w_opc);

   id_stage_reg_file u_reg_file (
      .clk      (clk),
      .rst      (rst),
      .i_we     (bus.wb_en),
      .i_waddr  (bus.wb_dest),
      .i_wdata  (bus.wb_value),
      .i_raddr1 (w_src1),
      .i_raddr2 (w_src2),
      .i_raddr3 (w_dest),
      .o_rdata1 (w_rd1),
      .o_rdata2 (w_rd2),
      .o_rdata3 (w_rd3)
   );

   // Load-use: the load in EX has not produced data yet for a register we read
   always_comb begin
      w_hazard = 1'b0;
      if (r_ex_mem_r && (r_ex_dest != '0)) begin
         w_hazard = (w_ctrl.rd_src1 && (w_src1 == r_ex_dest)) ||
                    (w_ctrl.rd_src2 && (w_src2 == r_ex_dest)) ||
                    (w_ctrl.rd_dest && (w_dest == r_ex_dest));
      end
   end

   // Branch condition from the (bypassed) register reads
   always_comb begin
      w_cond = 1'b0;
      case (w_ctrl.br)
         BR_EZ:   w_cond = (w_rd1 == '0);
         BR_NE:   w_cond = (w_rd1 != w_rd3);
         BR_JMP:  w_cond = 1'b1;
         default: w_cond = 1'b0;
      endcase
   end

   // A stalled branch may be reading stale operands, so it must not redirect
   assign w_taken   = ~rst & ~w_hazard & w_cond;
   assign w_br_addr = bus.pc_in + {w_imm_sext[DATA_W-3:0], 2'b00};
   assign w_load    = w_ctrl.valid & ~w_hazard & ~w_taken;

   // ID/EX pipeline register: data always captured, control zeroed on bubbles
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_pc     <= '0;
         r_ex_val1   <= '0;
         r_ex_val2   <= '0;
         r_ex_st_val <= '0;
         r_ex_dest   <= '0;
         r_ex_src1   <= '0;
         r_ex_src2   <= '0;
         r_ex_cmd    <= CMD_NOP;
         r_ex_mem_r  <= 1'b0;
         r_ex_mem_w  <= 1'b0;
         r_ex_wb     <= 1'b0;
      end else begin
         r_ex_pc     <= bus.pc_in;
         r_ex_val1   <= w_rd1;
         r_ex_val2   <= w_ctrl.use_imm ? w_imm_sext : w_rd2;
         r_ex_st_val <= w_rd3;
         if (w_load) begin
            r_ex_dest  <= w_dest;
            r_ex_src1  <= w_src1;
            r_ex_src2  <= w_ctrl.rd_src2 ? w_src2 : '0;
            r_ex_cmd   <= w_ctrl.cmd;
            r_ex_mem_r <= w_ctrl.mem_r;
            r_ex_mem_w <= w_ctrl.mem_w;
            r_ex_wb    <= w_ctrl.wb;
         end else begin
            r_ex_dest  <= '0;
            r_ex_src1  <= '0;
            r_ex_src2  <= '0;
            r_ex_cmd   <= CMD_NOP;
            r_ex_mem_r <= 1'b0;
            r_ex_mem_w <= 1'b0;
            r_ex_wb    <= 1'b0;
         end
      end
   end

   assign bus.br_taken  = w_taken;
   assign bus.br_addr   = w_br_addr;
   assign bus.hazard    = w_hazard;
   assign bus.ex_pc     = r_ex_pc;
   assign bus.ex_val1   = r_ex_val1;
   assign bus.ex_val2   = r_ex_val2;
   assign bus.ex_st_val = r_ex_st_val;
   assign bus.ex_dest   = r_ex_dest;
   assign bus.ex_src1   = r_ex_src1;
   assign bus.ex_src2   = r_ex_src2;
   assign bus.ex_cmd    = r_ex_cmd;
   assign bus.ex_mem_r  = r_ex_mem_r;
   assign bus.ex_mem_w  = r_ex_mem_w;
   assign bus.ex_wb     = r_ex_wb;

endmodule

// File: tb/tb_id_stage.sv
// Bench for the decode stage: directed scenarios with hand-derived
// expectations, then a randomized run checked against a behavioural model.
module tb_id_stage;
  import id_pkg::*;

  logic clk;
  logic rst;
  id_stage_if bus();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  logic [31:0] m_rf [32];
  logic [31:0] m_pc, m_v1, m_v2, m_st;
  logic [4:0]  m_dest, m_s1, m_s2;
  logic [3:0]  m_cmd;
  logic        m_mr, m_mw, m_wb;
  logic        m_hz, m_bt;
  logic [31:0] m_ba;
  logic [31:0] n_pc, n_v1, n_v2, n_st;
  logic [4:0]  n_dest, n_s1, n_s2;
  logic [3:0]  n_cmd;
  logic        n_mr, n_mw, n_wb;

  logic        obs_hz, obs_bt;
  logic [31:0] obs_ba;

  function automatic logic [31:0] mk_r(int op, int d, int s1, int s2);
    logic [5:0] o = op[5:0];
    logic [4:0] a = d[4:0];
    logic [4:0] b = s1[4:0];
    logic [4:0] c = s2[4:0];
    return {o, a, b, c, 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(int op, int d, int s1, logic [15:0] imm);
    logic [5:0] o = op[5:0];
    logic [4:0] a = d[4:0];
    logic [4:0] b = s1[4:0];
    return {o, a, b, imm};
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_dest == idx) return bus.wb_value;
    return m_rf[idx];
  endfunction

  // expected combinational outputs and next ID/EX contents from the ISA rules
  task automatic model_comb();
    int          opc;
    logic [4:0]  d, s1, s2;
    logic [31:0] simm;
    logic        is_rr, is_imm, r1, r2, rdd, cond, live;
    logic [3:0]  cmd;
    opc  = int'(bus.instr_in[31:26]);
    d    = bus.instr_in[25:21];
    s1   = bus.instr_in[20:16];
    s2   = bus.instr_in[15:11];
    simm = {{16{bus.instr_in[15]}}, bus.instr_in[15:0]};
    is_rr  = (opc == 1 || opc == 3 || opc == 5 || opc == 6 || opc == 8 || opc == 9 || opc == 10);
    is_imm = (opc == 32 || opc == 36 || opc == 37);
    case (opc)
      1, 32, 36, 37: cmd = CMD_ADD;
      3:  cmd = CMD_SUB;
      5:  cmd = CMD_AND;
      6:  cmd = CMD_OR;
      8:  cmd = CMD_XOR;
      9:  cmd = CMD_SLA;
      10: cmd = CMD_SRL;
      default: cmd = 4'd0;
    endcase
    r1  = is_rr || is_imm || opc == 40 || opc == 41;
    r2  = is_rr;
    rdd = (opc == 37 || opc == 41);
    m_hz = m_mr && m_dest != 0 &&
           ((r1 && s1 == m_dest) || (r2 && s2 == m_dest) || (rdd && d == m_dest));
    cond = (opc == 40 && m_read(s1) == 0) ||
           (opc == 41 && m_read(s1) != m_read(d)) ||
           (opc == 42);
    m_bt = !rst && !m_hz && cond;
    m_ba = bus.pc_in + simm * 4;
    live = (is_rr || is_imm) && !m_hz && !m_bt;
    n_pc   = bus.pc_in;
    n_v1   = m_read(s1);
    n_v2   = is_imm ? simm : m_read(s2);
    n_st   = m_read(d);
    n_cmd  = live ? cmd : 4'd0;
    n_wb   = live && opc != 37;
    n_mr   = live && opc == 36;
    n_mw   = live && opc == 37;
    n_dest = live ? d : 5'd0;
    n_s1   = live ? s1 : 5'd0;
    n_s2   = (live && is_rr) ? s2 : 5'd0;
  endtask

  task automatic model_seq();
    if (rst) begin
      {m_pc, m_v1, m_v2, m_st, m_dest, m_s1, m_s2, m_cmd, m_mr, m_mw, m_wb} = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      {m_pc, m_v1, m_v2, m_st, m_dest, m_s1, m_s2, m_cmd, m_mr, m_mw, m_wb} =
        {n_pc, n_v1, n_v2, n_st, n_dest, n_s1, n_s2, n_cmd, n_mr, n_mw, n_wb};
      if (bus.wb_en && bus.wb_dest != 0) m_rf[bus.wb_dest] = bus.wb_value;
    end
  endtask

  // driver: one clock with the currently applied inputs
  task automatic tick();
    model_comb();
    @(negedge clk);
    obs_hz = bus.hazard;
    obs_bt = bus.br_taken;
    obs_ba = bus.br_addr;
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic set_wb(logic en, int dest, logic [31:0] val);
    bus.wb_en    = en;
    bus.wb_dest  = dest[4:0];
    bus.wb_value = val;
  endtask

  task automatic test_reset();
    logic [31:0] v1, v2;
    rst = 1'b1;
    bus.instr_in = mk_r(1, 1, 1, 2);
    bus.pc_in = 32'h40;
    set_wb(1'b0, 0, 0);
    tick();
    tick();
    n_checks++;
    if ({bus.ex_pc, bus.ex_val1, bus.ex_val2, bus.ex_st_val, bus.ex_dest, bus.ex_src1,
         bus.ex_src2, bus.ex_cmd, bus.ex_mem_r, bus.ex_mem_w, bus.ex_wb} !== '0) begin
      n_fail++;
      $display("FAIL reset_ex: ex_cmd=%0d ex_wb=%0b ex_pc=%h, required all zero",
               bus.ex_cmd, bus.ex_wb, bus.ex_pc);
    end
    n_checks++;
    if (obs_bt !== 1'b0 || obs_hz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_comb: br_taken=%b hazard=%b, required 0/0", obs_bt, obs_hz);
    end
    // reset arriving mid-operation must also wipe the register file
    rst = 1'b0;
    set_wb(1'b1, 5, 32'hDEAD_BEEF);
    tick();
    rst = 1'b1;
    set_wb(1'b1, 6, 32'h1111_2222);
    tick();
    rst = 1'b0;
    set_wb(1'b0, 0, 0);
    for (int i = 1; i < 32; i++) begin
      bus.instr_in = mk_r(1, 1, i, i);
      tick();
      v1 = bus.ex_val1;
      v2 = bus.ex_val2;
      n_checks++;
      if (v1 !== 32'd0 || v2 !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_rf r%0d: read %h/%h, required 0", i, v1, v2);
      end
    end
  endtask

  task automatic test_wb_decode();
    set_wb(1'b1, 1, 32'd5);
    bus.instr_in = 32'd0;
    tick();
    set_wb(1'b0, 0, 0);
    bus.instr_in = mk_i(32, 2, 1, 16'hFFFD);
    tick();
    n_checks++;
    if (bus.ex_val1 !== 32'd5 || bus.ex_val2 !== 32'hFFFF_FFFD || bus.ex_cmd !== CMD_ADD ||
        bus.ex_wb !== 1'b1 || bus.ex_dest !== 5'd2) begin
      n_fail++;
      $display("FAIL addi: val1=%h val2=%h cmd=%0d wb=%b dest=%0d, required 5/fffffffd/1/1/2",
               bus.ex_val1, bus.ex_val2, bus.ex_cmd, bus.ex_wb, bus.ex_dest);
    end
  endtask

  task automatic test_bypass();
    set_wb(1'b1, 3, 32'h1234);
    bus.instr_in = mk_r(1, 4, 3, 0);
    tick();
    n_checks++;
    if (bus.ex_val1 !== 32'h1234 || bus.ex_val2 !== 32'd0) begin
      n_fail++;
      $display("FAIL bypass: val1=%h val2=%h, required 00001234/0", bus.ex_val1, bus.ex_val2);
    end
    set_wb(1'b1, 0, 32'd7);
    bus.instr_in = mk_r(1, 4, 0, 0);
    tick();
    n_checks++;
    if (bus.ex_val1 !== 32'd0) begin
      n_fail++;
      $display("FAIL r0_write_cycle: val1=%h, required 0", bus.ex_val1);
    end
    set_wb(1'b0, 0, 0);
    tick();
    n_checks++;
    if (bus.ex_val1 !== 32'd0 || bus.ex_val2 !== 32'd0) begin
      n_fail++;
      $display("FAIL r0_after: val1=%h val2=%h, required 0", bus.ex_val1, bus.ex_val2);
    end
  endtask

  task automatic test_load_use();
    set_wb(1'b0, 0, 0);
    bus.instr_in = mk_i(36, 6, 0, 16'd0);
    tick();
    n_checks++;
    if (bus.ex_mem_r !== 1'b1 || bus.ex_dest !== 5'd6) begin
      n_fail++;
      $display("FAIL ld_issue: mem_r=%b dest=%0d, required 1/6", bus.ex_mem_r, bus.ex_dest);
    end
    bus.instr_in = mk_r(1, 7, 6, 0);
    tick();
    n_checks++;
    if (obs_hz !== 1'b1 || bus.ex_cmd !== 4'd0 || bus.ex_wb !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_use_stall: hazard=%b cmd=%0d wb=%b, required 1/0/0",
               obs_hz, bus.ex_cmd, bus.ex_wb);
    end
    tick();
    n_checks++;
    if (obs_hz !== 1'b0 || bus.ex_cmd !== CMD_ADD || bus.ex_src1 !== 5'd6 || bus.ex_wb !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_use_release: hazard=%b cmd=%0d src1=%0d wb=%b, required 0/1/6/1",
               obs_hz, bus.ex_cmd, bus.ex_src1, bus.ex_wb);
    end
    bus.instr_in = mk_i(36, 0, 0, 16'd0);
    tick();
    bus.instr_in = mk_r(1, 7, 0, 0);
    tick();
    n_checks++;
    if (obs_hz !== 1'b0 || bus.ex_cmd !== CMD_ADD) begin
      n_fail++;
      $display("FAIL ld_r0: hazard=%b cmd=%0d, required 0/1", obs_hz, bus.ex_cmd);
    end
  endtask

  task automatic test_branch();
    set_wb(1'b0, 0, 0);
    bus.pc_in = 32'd8;
    bus.instr_in = mk_i(40, 0, 0, 16'd4);
    tick();
    n_checks++;
    if (obs_bt !== 1'b1 || obs_ba !== 32'd24) begin
      n_fail++;
      $display("FAIL bez: br_taken=%b br_addr=%0d, required 1/24", obs_bt, obs_ba);
    end
    n_checks++;
    if (bus.ex_cmd !== 4'd0 || bus.ex_wb !== 1'b0 || bus.ex_dest !== 5'd0 ||
        bus.ex_mem_r !== 1'b0 || bus.ex_mem_w !== 1'b0) begin
      n_fail++;
      $display("FAIL bez_bubble: cmd=%0d wb=%b dest=%0d, required 0/0/0",
               bus.ex_cmd, bus.ex_wb, bus.ex_dest);
    end
    bus.instr_in = mk_i(41, 3, 3, 16'd10);
    tick();
    n_checks++;
    if (obs_bt !== 1'b0) begin
      n_fail++;
      $display("FAIL bne_equal: br_taken=%b, required 0", obs_bt);
    end
    bus.pc_in = 32'd16;
    bus.instr_in = mk_i(42, 0, 0, 16'hFFFE);
    tick();
    n_checks++;
    if (obs_bt !== 1'b1 || obs_ba !== 32'd8) begin
      n_fail++;
      $display("FAIL jmp: br_taken=%b br_addr=%0d, required 1/8", obs_bt, obs_ba);
    end
  endtask

  task automatic test_illegal();
    set_wb(1'b1, 5, 32'd0);
    bus.instr_in = mk_i(36, 5, 0, 16'd0);
    tick();
    set_wb(1'b0, 0, 0);
    bus.instr_in = mk_r(63, 5, 5, 5);
    tick();
    n_checks++;
    if (obs_hz !== 1'b0 || obs_bt !== 1'b0 || bus.ex_cmd !== 4'd0 || bus.ex_wb !== 1'b0 ||
        bus.ex_mem_r !== 1'b0 || bus.ex_mem_w !== 1'b0 || bus.ex_dest !== 5'd0) begin
      n_fail++;
      $display("FAIL illegal: hazard=%b br=%b cmd=%0d wb=%b mr=%b mw=%b dest=%0d, required all 0",
               obs_hz, obs_bt, bus.ex_cmd, bus.ex_wb, bus.ex_mem_r, bus.ex_mem_w, bus.ex_dest);
    end
  endtask

  task automatic test_random();
    int ops[14] = '{0, 1, 3, 5, 6, 8, 9, 10, 32, 36, 37, 40, 41, 42};
    int k, op;
    logic [31:0] exp_v, got_v;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_wb($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 3) == 0 ? 32'd0 : $urandom);
      if (!obs_hz) begin
        k = $urandom_range(0, 15);
        op = (k < 14) ? ops[k] : $urandom_range(0, 63);
        bus.instr_in = {op[5:0], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 11'($urandom)};
        bus.pc_in = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      end
      tick();
      n_checks++;
      if (obs_hz !== m_hz || obs_bt !== m_bt || (m_bt && obs_ba !== m_ba)) begin
        n_fail++;
        $display("FAIL rand_comb #%0d: hz=%b bt=%b ba=%h, required %b/%b/%h",
                 n, obs_hz, obs_bt, obs_ba, m_hz, m_bt, m_ba);
      end
      got_v = {bus.ex_dest, bus.ex_src1, bus.ex_src2, bus.ex_cmd, bus.ex_mem_r, bus.ex_mem_w, bus.ex_wb, 10'd0};
      exp_v = {m_dest, m_s1, m_s2, m_cmd, m_mr, m_mw, m_wb, 10'd0};
      n_checks++;
      if (got_v !== exp_v || bus.ex_pc !== m_pc || bus.ex_val1 !== m_v1 ||
          bus.ex_val2 !== m_v2 || bus.ex_st_val !== m_st) begin
        n_fail++;
        $display("FAIL rand_ex #%0d: ctl=%h pc=%h v1=%h v2=%h st=%h, required ctl=%h pc=%h v1=%h v2=%h st=%h",
                 n, got_v, bus.ex_pc, bus.ex_val1, bus.ex_val2, bus.ex_st_val,
                 exp_v, m_pc, m_v1, m_v2, m_st);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    {m_pc, m_v1, m_v2, m_st, m_dest, m_s1, m_s2, m_cmd, m_mr, m_mw, m_wb} = '0;
    obs_hz = 1'b0;
    obs_bt = 1'b0;
    obs_ba = 32'd0;
    rst = 1'b1;
    bus.pc_in = 32'd0;
    bus.instr_in = 32'd0;
    set_wb(1'b0, 0, 0);
    test_reset();
    test_wb_decode();
    test_bypass();
    test_load_use();
    test_branch();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage pipeline. Sits directly downstream of the fetch stage.
- Consumes the fetched pc/instruction pair, reads the 32x32 register file and decodes the opcode.
- Resolves branches and drives the branch-taken/target back to fetch.
- Detects load-use hazards and registers everything into the ID/EX pipeline register.

Parameters:
- REG_COUNT, 32, number of architectural registers; r0 reads as 0.
- DATA_W, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- pc_in  in  32  pc+4 of fetched instruction (from fetch)
- instr_in  in  32  fetched instruction
- wb_en  in  1  write-back enable
- wb_dest  in  5  write-back register index
- wb_value  in  32  write-back data
- br_taken  out  1  branch/jump taken; also the fetch flush
- br_addr  out  32  branch target
- hazard  out  1  load-use stall; fetch holds pc and IF register
- ex_pc  out  32  registered pc
- ex_val1  out  32  registered src1 value
- ex_val2  out  32  registered second operand (reg or sign-extended imm)
- ex_st_val  out  32  registered store data (reg[dest])
- ex_dest  out  5  registered destination
- ex_src1  out  5  registered src1 index, for the forwarding unit
- ex_src2  out  5  registered src2 index, for the forwarding unit
- ex_cmd  out  4  registered ALU command
- ex_mem_r  out  1  registered load
- ex_mem_w  out  1  registered store
- ex_wb  out  1  registered write-back enable

Behaviour:
- Instruction format:
  - opcode[31:26], dest[25:21], src1[20:16], src2[15:11], imm[15:0].
  - imm is sign-extended to 32 bits.
- Opcodes and ALU commands:
  - NOP 0 -> all control 0.
  - ADD 1 / SUB 3 / AND 5 / OR 6 / XOR 8 / SLA 9 / SRL 10: reg-reg, wb=1.
  - ADDI 32: reg-imm add, wb=1.
  - LD 36: mem_r=1, wb=1, val2=imm.
  - ST 37: mem_w=1, val2=imm, st_val=reg[dest].
  - BEZ 40: taken if reg[src1]==0.
  - BNE 41: taken if reg[src1]!=reg[dest].
  - JMP 42: always taken.
  - Any other opcode decodes as NOP.
- Branch resolution:
  - br_addr = pc_in + (sext(imm)<<2), modulo 2^32.
  - br_taken is combinational from the current instr_in and the register read.
  - br_taken is forced 0 while hazard=1 or rst=1.
  - Branches write nothing and enter ID/EX as a bubble.
- Register file:
  - Written on rising clk when wb_en=1 and wb_dest!=0.
  - Writes to r0 are ignored.
  - Internal bypass: a read of the same index in the write cycle returns wb_value.
  - Reset clears all registers to 0.
- Hazard:
  - hazard=1 when ex_mem_r=1, ex_dest!=0, and the current instruction reads ex_dest.
  - "Reads" means src1 for all non-NOP/JMP opcodes; src2 for reg-reg ops; dest for ST/BNE.
- ID/EX register, on each rising clk:
  - rst: all ex_* outputs = 0.
  - else if hazard or br_taken: bubble. Control fields (cmd, mem_r, mem_w, wb, dest, src1, src2) = 0; data fields may be loaded.
  - else: load decoded values.
- Latency: decoded instruction appears on ex_* exactly 1 cycle after it is presented on instr_in.
- Reset mid-operation clears the pipeline register and the register file in the same edge.

Decomposition:
- Package id_pkg holds:
  - opcode localparams;
  - ALU command encodings (4-bit);
  - field bit positions;
  - a decoded-control struct.
- Sub-module reg_file: 32x32, two read ports plus a third read port for dest, one write port, r0 fixed at 0, internal bypass.

Test Plan:
1. Reset: assert rst 2 cycles with instr_in=ADD -> all ex_* = 0, br_taken=0, hazard=0, reads of r1..r31 return 0.
2. Write-back and decode:
   - Stimulus: wb_en=1, wb_dest=1, wb_value=5; next cycle instr_in = ADDI dest=2 src1=1 imm=-3.
   - Response: next edge ex_val1=5, ex_val2=0xFFFFFFFD, ex_cmd=ADD, ex_wb=1, ex_dest=2.
3. Same-cycle bypass and r0:
   - Stimulus: wb to r3=0x1234 while instr_in = ADD dest=4 src1=3 src2=0.
   - Response: ex_val1=0x1234, ex_val2=0. A write of 7 to r0 leaves r0 reading 0.
4. Load-use:
   - Stimulus: LD dest=6 followed by ADD src1=6.
   - Response: hazard=1 for exactly 1 cycle; bubble (ex_cmd=0, ex_wb=0); ADD then appears the following cycle.
   - ADD src1=0 after LD dest=0 gives hazard=0.
5. Branches:
   - BEZ src1=r0, imm=4, pc_in=8 -> br_taken=1, br_addr=24, next ex_* is a bubble.
   - BNE with equal registers -> br_taken=0.
   - JMP imm=-2, pc_in=16 -> br_addr=8.
6. Illegal opcode 63 -> decodes as NOP (all control 0), no hazard, no branch.
